// File: rtl/dec_enc_pkg.sv
// Shared types and helpers for the request decoder/encoder family.
// Used by enc4_2_seq and its priority picker.
package dec_enc_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef logic [N_REQ-1:0] req_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic req_t onehot(input idx_t idx);
    req_t r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/enc4_2_seq_prio_pick4.sv
// Rotating-start priority picker over four request lines.
// The first set bit found at or after 'start' (wrapping) wins.
module prio_pick4
  import dec_enc_pkg::*;
(
  input  req_t req,
  input  idx_t start,
  output idx_t idx,
  output logic any
);

  idx_t cand;

  // Walk from the farthest offset down so the nearest set bit wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start + idx_t'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc4_2_seq.sv
// Clocked 4-to-2 request encoder: collects multi-hot requests into a pending
// set and serializes them over valid/ready. Define ENC4_2_RR_EN for round-robin.
module enc4_2_seq #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int RST_PTR = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E,
  input  logic [N_REQ-1:0] I,
  input  logic             out_ready,
  output logic [IDX_W-1:0] Y,
  output logic             V,
  output logic             merge,
  output logic             busy
);

  import dec_enc_pkg::*;

  if (N_REQ != 4 || IDX_W != 2 || RST_PTR < 0 || RST_PTR >= N_REQ) begin : g_param_check
    $error("enc4_2_seq: only N_REQ=4, IDX_W=2, 0<=RST_PTR<4 are supported");
  end

  req_t pending;
  req_t in_req;
  req_t eff;
  logic load;
  idx_t start;
  idx_t pick_idx;
  logic pick_any;

  assign in_req = E ? I : '0;
  assign eff    = pending | in_req;
  assign load   = !V || out_ready;
  assign busy   = (pending != '0) || V;

`ifdef ENC4_2_RR_EN
  idx_t last_ptr;

  // Search begins just past the last grant so no line can starve another.
  assign start = last_ptr + idx_t'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ptr <= idx_t'(RST_PTR);
    end else if (load && pick_any) begin
      last_ptr <= pick_idx;
    end
  end
`else
  assign start = '0;
`endif

  prio_pick4 u_pick (
    .req   (eff),
    .start (start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Output/pending register stage; merge looks at pending before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      Y       <= '0;
      V       <= 1'b0;
      merge   <= 1'b0;
    end else begin
      merge <= |(in_req & pending);
      if (load) begin
        if (pick_any) begin
          V       <= 1'b1;
          Y       <= pick_idx;
          pending <= eff & ~onehot(pick_idx);
        end else begin
          V       <= 1'b0;
        end
      end else begin
        pending <= eff;
      end
    end
  end

endmodule
